// File: rtl/core_pkg.sv
// Shared micro-op encoding: NOP word, field bit positions, exec FSM encoding.
// Definitions only; no logic.
package core_pkg;
    localparam int OP_W = 20;
    localparam logic [OP_W-1:0] NOP_WORD = 20'b0000_0000_1111_00_000_000;

    localparam int IDX_A_LSB   = 0;
    localparam int IDX_B_LSB   = 3;
    localparam int SEL_LSB     = 6;
    localparam int DEST_LSB    = 8;
    localparam int WIDTH_BIT   = 8;
    localparam int DEST_MID    = 9;
    localparam int DEST_MSB    = 10;
    localparam int REG_N_BIT   = 11;
    localparam int FLAGS_BIT   = 12;
    localparam int MEM_CMD_BIT = 13;
    localparam int MEM_AUX_BIT = 14;
    localparam int CARRY_N_BIT = 15;
    localparam int ALU_LSB     = 16;

    typedef enum logic {EXEC = 1'b0, MEM_WAIT = 1'b1} exec_state_t;

    function automatic logic is_mem_op(input logic [OP_W-1:0] w);
        return w[MEM_CMD_BIT] | w[MEM_AUX_BIT];
    endfunction
endpackage

// File: rtl/uop_fifo.sv
// Circular entry store with push/pop/flush and occupancy count.
// Latency: pushed entry visible on dout the cycle after push into empty store.
// Backpressure: caller must not push when full nor pop when empty; flush wins over both.
module uop_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   a_rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    assign dout = mem[rd_ptr];
endmodule

// File: rtl/uop_exec_queue.sv
// Micro-op queue with head decode and a memory-wait FSM.
// Latency: op reaches head one cycle after push; non-memory op retires the next edge.
// Backpressure: in_ready from registered count only; stop freezes retire, mem wait holds head.
module uop_exec_queue
    import core_pkg::*;
#(
    parameter int UOP_W  = 20,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   a_rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [UOP_W-1:0]       in_uop,
    input  logic [DATA_W-1:0]      in_temp_a,
    input  logic [DATA_W-1:0]      in_temp_b,
    input  logic                   in_sched,
    input  logic                   in_main,
    input  logic                   stop,
    input  logic                   flush,
    input  logic                   mem_ack,
    output logic [DATA_W-1:0]      t16,
    output logic [2:0]             idx_a,
    output logic [2:0]             idx_b,
    output logic [2:0]             idx_dest,
    output logic [1:0]             sel_inp,
    output logic [3:0]             alu_f,
    output logic                   carry_mask,
    output logic                   flags_w,
    output logic                   reg_wr,
    output logic                   mar_wr,
    output logic                   mem_rq_data,
    output logic                   mem_rq_width,
    output logic                   mem_rq_cmd,
    output logic                   mem_rq,
    output logic                   sched_main,
    output logic                   head_valid,
    output logic [$clog2(DEPTH):0] count
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = UOP_W + DATA_W + 2;

    typedef struct packed {
        logic [UOP_W-1:0]  uop;
        logic [DATA_W-1:0] temp;
        logic              sched;
        logic              main;
    } entry_t;

    entry_t          push_ent;
    entry_t          head_ent;
    logic [EW-1:0]   head_raw;
    logic            push;
    logic            pop;
    logic            en;
    logic            mem_op;
    logic [OP_W-1:0] w;
    exec_state_t     state_q;
    exec_state_t     state_d;
    logic            sched_q;
    logic            unused_bits;

    assign in_ready = (count < CW'(DEPTH)) & ~flush;
    assign push     = in_valid & in_ready;

    always_comb begin
        push_ent       = '0;
        push_ent.uop   = in_uop;
        push_ent.temp  = in_sched ? in_temp_b : in_temp_a;
        push_ent.sched = in_sched;
        push_ent.main  = in_main;
    end

    uop_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .a_rst (a_rst),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (push_ent),
        .dout  (head_raw),
        .count (count)
    );

    assign head_ent   = head_raw;
    assign head_valid = (count != '0);
    // Empty queue decodes as NOP so downstream sees benign controls.
    assign w      = head_valid ? head_ent.uop[OP_W-1:0] : NOP_WORD;
    assign t16    = head_valid ? head_ent.temp : '0;
    assign mem_op = is_mem_op(w);
    assign en     = head_valid & ~stop & (state_q == EXEC);

    assign idx_a        = w[IDX_A_LSB +: 3];
    assign idx_b        = w[IDX_B_LSB +: 3];
    assign sel_inp      = w[SEL_LSB +: 2];
    assign idx_dest     = w[DEST_LSB +: 3];
    assign alu_f        = w[ALU_LSB +: 4];
    assign carry_mask   = ~w[CARRY_N_BIT];
    assign mem_rq_cmd   = w[MEM_CMD_BIT];
    assign reg_wr       = ~w[REG_N_BIT] & en;
    assign flags_w      = w[FLAGS_BIT] & en;
    assign mar_wr       = w[REG_N_BIT] & ~w[DEST_MSB] & ~w[DEST_MID] & en;
    assign mem_rq_data  = mar_wr;
    assign mem_rq_width = mar_wr & w[WIDTH_BIT];
    assign mem_rq       = mem_op & en;

    // Acknowledge completes the wait even under stop; flush abandons it.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        if (flush) begin
            state_d = EXEC;
        end else begin
            case (state_q)
                EXEC: begin
                    if (en) begin
                        if (mem_op) state_d = MEM_WAIT;
                        else        pop     = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (mem_ack) begin
                        pop     = 1'b1;
                        state_d = EXEC;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            state_q    <= EXEC;
            sched_q    <= 1'b0;
            sched_main <= 1'b0;
        end else begin
            state_q <= state_d;
            if (pop) begin
                sched_q    <= head_ent.sched;
                sched_main <= head_ent.main;
            end
        end
    end

    assign unused_bits = ^{sched_q, head_ent.uop};
endmodule

// File: doc/uop_exec_queue.md
UOP_EXEC_QUEUE -- requirements
Module: uop_exec_queue

Interface
REQ-001 SHALL have parameter UOP_W, default 20, micro-op width (field map below fixed for bits 19:0; bits above 19 ignored).
REQ-002 SHALL have parameter DATA_W, default 16, temporary operand width.
REQ-003 SHALL have parameter DEPTH, default 4, queue entries (power of two, >=2).
REQ-004 SHALL have ports:
- clk  in  1  clock.
- a_rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  micro-op offered.
- in_ready  out  1  queue can accept.
- in_uop  in  UOP_W  offered micro-op.
- in_temp_a, in_temp_b  in  DATA_W  operand candidates.
- in_sched, in_main  in  1  scheduler flags for the offered op.
- stop  in  1  pipeline stall.
- flush  in  1  discard all queued ops.
- mem_ack  in  1  memory request completion.
- t16  out  DATA_W  head operand.
- idx_a, idx_b, idx_dest  out  3 each  register indices.
- sel_inp  out  2  input select.
- alu_f  out  4  ALU function.
- carry_mask, flags_w, reg_wr, mar_wr, mem_rq_data, mem_rq_width, mem_rq_cmd, mem_rq  out  1 each  decoded controls.
- sched_main  out  1  retired main flag.
- head_valid  out  1  head entry valid.
- count  out  clog2(DEPTH)+1  occupancy.

Function
REQ-005 SHALL push an entry when in_valid & in_ready; entry stores uop, temp = in_sched ? in_temp_b : in_temp_a, in_sched, in_main.
REQ-006 SHALL drive in_ready = (count < DEPTH) & ~flush, registered-count only (no combinational path from in_valid/mem_ack).
REQ-007 SHALL decode outputs from the head entry; when queue empty SHALL decode the NOP word 20'b0000_0000_1111_00_000_000 and t16 = 0.
REQ-008 Field map: idx_a=[2:0], idx_b=[5:3], sel_inp=[7:6], idx_dest=[10:8], alu_f=[19:16], carry_mask=~[15], mem_rq_cmd=[13].
REQ-009 SHALL gate strobes with en = head_valid & ~stop & (state==EXEC): reg_wr=~[11]&en, flags_w=[12]&en, mar_wr=[11]&~[10]&~[9]&en, mem_rq_data=mar_wr, mem_rq_width=mar_wr&[8], mem_rq=([13]|[14])&en.
REQ-010 SHALL implement FSM states EXEC, MEM_WAIT.
REQ-011 In EXEC with en: if head is memory op ([13]|[14]) go MEM_WAIT, else retire head same edge.
REQ-012 In MEM_WAIT SHALL hold head, deassert all strobes, and on mem_ack retire head and return to EXEC; stop does not block acknowledge.
REQ-013 Retire SHALL update sched_main register from head main flag; sched register likewise (internal).
REQ-014 Simultaneous push and retire SHALL leave count unchanged; push at count==DEPTH SHALL not occur; pointers wrap modulo DEPTH.
REQ-015 flush SHALL, on the next edge, empty the queue, return FSM to EXEC, abandon any pending mem wait (later mem_ack ignored), and block push that cycle; sched_main retained.
REQ-016 stop SHALL freeze queue contents, FSM (except REQ-012), and sched_main; push still permitted when in_ready.
REQ-017 Latency: op pushed into empty queue appears at head the following cycle; non-memory op retires one cycle after reaching head absent stop.

Reset
REQ-018 a_rst low SHALL asynchronously clear pointers, count=0, FSM=EXEC, sched=0, main=0, storage temp=0; outputs thus show NOP decode, t16=0, head_valid=0, all strobes 0, in_ready=1 after release.

Structure
REQ-019 NOP word, field bit positions and FSM encoding SHALL live in shared package core_pkg.
REQ-020 Storage SHALL be a sub-module uop_fifo (parametrised width/depth, push/pop/flush, count); decode and FSM in top.

Verification
REQ-021 Reset: a_rst low mid-MEM_WAIT -> count=0, mem_rq=0, NOP decode, sched_main=0.
REQ-022 Push uop 0x0_0_0_3_01 (reg op) with temp_a=0x1234, in_sched=0 -> next cycle reg_wr=1, t16=0x1234, retires following edge, count 1->0.
REQ-023 Push memory op with bits 11,13 set, 8 set -> mem_rq=1, mar_wr=1, mem_rq_width=1 one cycle; strobes 0 until mem_ack pulse 3 cycles later; then retire.
REQ-024 Push DEPTH=4 ops with stop=1 -> count=4, in_ready=0; drop stop -> drains in order, one per cycle.
REQ-025 flush during MEM_WAIT with 3 queued -> next cycle count=0, FSM EXEC, late mem_ack has no effect.
REQ-026 Simultaneous push and retire at count=2 -> count stays 2, order preserved across pointer wrap.
